// File: rtl/seg_scan_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : seg_scan_ctrl
// Purpose  : 8-digit multiplexed 7-segment scanner with per-digit DRIVE/GAP timing.
//            Define SEG_LZ_BLANK_EN to blank leading zero digits.
// Revision : 1.0  initial release
// ============================================================================
module seg_scan_ctrl #(
  parameter int unsigned SCAN_DIV = 50000,
  parameter int unsigned GAP_CYC  = 8
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       disp_on,
  input  logic       wr_en,
  input  logic [2:0] wr_addr,
  input  logic [4:0] wr_data,
  output logic [7:0] seg,
  output logic [7:0] en,
  output logic [2:0] digit_idx
);

  localparam logic [15:0] C_DIV_LAST = 16'(SCAN_DIV - 1);
  localparam logic [15:0] C_GAP_LAST = 16'(GAP_CYC - 1);

  typedef enum logic [1:0] {
    S_OFF   = 2'd0,
    S_DRIVE = 2'd1,
    S_GAP   = 2'd2
  } state_t;

  state_t      r_state, w_state_nxt;
  logic [15:0] r_cnt, w_cnt_nxt;
  logic [2:0]  r_idx, w_idx_nxt;
  logic [4:0]  r_digit [8];
  logic [4:0]  w_cur;
  logic        w_blank;

  function automatic logic [6:0] f_decode(input logic [3:0] v);
    case (v)
      4'h0: f_decode = 7'h40;
      4'h1: f_decode = 7'h79;
      4'h2: f_decode = 7'h24;
      4'h3: f_decode = 7'h30;
      4'h4: f_decode = 7'h19;
      4'h5: f_decode = 7'h12;
      4'h6: f_decode = 7'h02;
      4'h7: f_decode = 7'h78;
      4'h8: f_decode = 7'h00;
      4'h9: f_decode = 7'h10;
      4'hA: f_decode = 7'h08;
      4'hB: f_decode = 7'h03;
      4'hC: f_decode = 7'h46;
      4'hD: f_decode = 7'h21;
      4'hE: f_decode = 7'h06;
      default: f_decode = 7'h0E;
    endcase
  endfunction

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int i = 0; i < 8; i++) r_digit[i] <= 5'd0;
    end else if (wr_en) begin
      r_digit[wr_addr] <= wr_data;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state <= S_OFF;
      r_cnt   <= 16'd0;
      r_idx   <= 3'd0;
    end else begin
      r_state <= w_state_nxt;
      r_cnt   <= w_cnt_nxt;
      r_idx   <= w_idx_nxt;
    end
  end

  assign w_cur = r_digit[r_idx];

`ifdef SEG_LZ_BLANK_EN
  // w_lz[i]: digit i and every digit above it are zero with dp off
  logic [7:0] w_lz;
  assign w_lz[7] = (r_digit[7] == 5'd0);
  assign w_lz[0] = 1'b0;
  for (genvar gi = 1; gi < 7; gi++) begin : g_lz
    assign w_lz[gi] = (r_digit[gi] == 5'd0) && w_lz[gi+1];
  end
  assign w_blank = w_lz[r_idx];
`else
  assign w_blank = 1'b0;
`endif

  always_comb begin
    w_state_nxt = r_state;
    w_cnt_nxt   = r_cnt;
    w_idx_nxt   = r_idx;
    en          = 8'hFF;
    seg         = 8'hFF;
    case (r_state)
      S_OFF: begin
        if (disp_on) begin
          w_state_nxt = S_DRIVE;
          w_cnt_nxt   = 16'd0;
        end
      end
      S_DRIVE: begin
        en = ~(8'h01 << r_idx);
        if (!w_blank) seg = {~w_cur[4], f_decode(w_cur[3:0])};
        if (!disp_on) begin
          w_state_nxt = S_OFF;
          w_cnt_nxt   = 16'd0;
        end else if (r_cnt == C_DIV_LAST) begin
          w_cnt_nxt = 16'd0;
          if (GAP_CYC == 0) begin
            w_idx_nxt = r_idx + 3'd1;
          end else begin
            w_state_nxt = S_GAP;
          end
        end else begin
          w_cnt_nxt = r_cnt + 16'd1;
        end
      end
      S_GAP: begin
        if (!disp_on) begin
          w_state_nxt = S_OFF;
          w_cnt_nxt   = 16'd0;
        end else if (r_cnt == C_GAP_LAST) begin
          w_state_nxt = S_DRIVE;
          w_cnt_nxt   = 16'd0;
          w_idx_nxt   = r_idx + 3'd1;
        end else begin
          w_cnt_nxt = r_cnt + 16'd1;
        end
      end
      default: begin
        w_state_nxt = S_OFF;
        w_cnt_nxt   = 16'd0;
      end
    endcase
  end

  assign digit_idx = r_idx;

endmodule
`default_nettype wire

// File: tb/tb_seg_scan_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : tb_seg_scan_ctrl
// Purpose  : Checks two scanner instances (GAP_CYC=2 and GAP_CYC=0) against a
//            position-based model plus directed literal expectations.
// Revision : 1.0  initial release
// ============================================================================
module tb_seg_scan_ctrl;

  localparam int DIV = 4;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic       disp_on = 1'b0;
  logic       wr_en = 1'b0;
  logic [2:0] wr_addr = 3'd0;
  logic [4:0] wr_data = 5'd0;
  logic [7:0] seg_a, en_a, seg_b, en_b;
  logic [2:0] idx_a, idx_b;

  int total = 0;
  int bad   = 0;
  int k     = 0;
  int nfb   = 0;

`ifdef SEG_LZ_BLANK_EN
  localparam bit LZ = 1'b1;
`else
  localparam bit LZ = 1'b0;
`endif

  seg_scan_ctrl #(.SCAN_DIV(DIV), .GAP_CYC(2)) dut_a (
    .clk(clk), .rst(rst), .disp_on(disp_on), .wr_en(wr_en), .wr_addr(wr_addr),
    .wr_data(wr_data), .seg(seg_a), .en(en_a), .digit_idx(idx_a)
  );

  seg_scan_ctrl #(.SCAN_DIV(DIV), .GAP_CYC(0)) dut_b (
    .clk(clk), .rst(rst), .disp_on(disp_on), .wr_en(wr_en), .wr_addr(wr_addr),
    .wr_data(wr_data), .seg(seg_b), .en(en_b), .digit_idx(idx_b)
  );

  always #5 clk = ~clk;

  // Model: a display is either off or at position pos within a digit slot of
  // DIV lit cycles followed by gap dark cycles.
  typedef struct packed {
    logic       on;
    logic [2:0] idx;
    int         pos;
  } mst_t;

  mst_t       ma, mb;
  logic [4:0] mreg [8];
  logic [6:0] dec [16];

  initial begin
    dec[0]  = 7'h40; dec[1]  = 7'h79; dec[2]  = 7'h24; dec[3]  = 7'h30;
    dec[4]  = 7'h19; dec[5]  = 7'h12; dec[6]  = 7'h02; dec[7]  = 7'h78;
    dec[8]  = 7'h00; dec[9]  = 7'h10; dec[10] = 7'h08; dec[11] = 7'h03;
    dec[12] = 7'h46; dec[13] = 7'h21; dec[14] = 7'h06; dec[15] = 7'h0E;
  end

  function automatic mst_t step(input mst_t s, input logic don, input int gap);
    mst_t n;
    n = s;
    if (!s.on) begin
      if (don) begin n.on = 1'b1; n.pos = 0; end
    end else if (!don) begin
      n.on = 1'b0; n.pos = 0;
    end else begin
      n.pos = s.pos + 1;
      if (n.pos == DIV + gap) begin n.pos = 0; n.idx = s.idx + 3'd1; end
    end
    return n;
  endfunction

  function automatic logic [7:0] exp_en(input mst_t s);
    if (s.on && s.pos < DIV) return ~(8'h01 << s.idx);
    return 8'hFF;
  endfunction

  function automatic logic [7:0] exp_seg(input mst_t s);
    logic [4:0] d;
    bit         lead;
    if (!(s.on && s.pos < DIV)) return 8'hFF;
    lead = (s.idx != 0);
    for (int j = 0; j < 8; j++)
      if (j >= int'(s.idx) && mreg[j] != 5'd0) lead = 1'b0;
    if (LZ && lead) return 8'hFF;
    d = mreg[s.idx];
    return {~d[4], dec[d[3:0]]};
  endfunction

  always @(posedge clk or negedge rst) begin
    if (!rst) begin
      ma <= '0;
      mb <= '0;
      for (int i = 0; i < 8; i++) mreg[i] <= 5'd0;
    end else begin
      ma <= step(ma, disp_on, 2);
      mb <= step(mb, disp_on, 0);
      if (wr_en) mreg[wr_addr] <= wr_data;
    end
  end

  task automatic chk(input string name, input logic [7:0] act, input logic [7:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %02h want %02h (t=%0t)", name, act, exp, $time);
    end
  endtask

  always @(negedge clk) begin
    chk("model_en_a",  en_a,  exp_en(ma));
    chk("model_seg_a", seg_a, exp_seg(ma));
    chk("model_idx_a", {5'd0, idx_a}, {5'd0, ma.idx});
    chk("model_en_b",  en_b,  exp_en(mb));
    chk("model_seg_b", seg_b, exp_seg(mb));
    chk("model_idx_b", {5'd0, idx_b}, {5'd0, mb.idx});
  end

  task automatic run_to(input int t);
    while (k < t) begin
      @(negedge clk);
      k++;
      if (k < 32 && en_b == 8'hFF) nfb++;
    end
  endtask

  initial begin
    repeat (3) @(negedge clk);
    chk("rst_en",  en_a, 8'hFF);
    chk("rst_seg", seg_a, 8'hFF);
    chk("rst_idx", {5'd0, idx_a}, 8'h00);

    rst = 1'b1;
    disp_on = 1'b1;
    @(negedge clk);
    k = 0;
    chk("first_en",  en_a, 8'hFE);
    chk("first_seg", seg_a, 8'hC0);
    chk("first_en_b", en_b, 8'hFE);

    run_to(3);  chk("scan_k3",  en_a, 8'hFE);
    run_to(4);  chk("scan_gap", en_a, 8'hFF); chk("g0_k4", en_b, 8'hFD);
    run_to(6);  chk("scan_d1",  en_a, 8'hFD);
    run_to(8);  chk("g0_k8",    en_b, 8'hFB);
    run_to(42); chk("scan_d7",  en_a, 8'h7F);
    run_to(47); chk("scan_k47", en_a, 8'hFF);
    run_to(48); chk("scan_wrap", en_a, 8'hFE);
    chk("g0_no_gap", 8'(nfb), 8'd0);

    run_to(67); chk("live_en", en_a, 8'hF7);
    wr_en = 1'b1; wr_addr = 3'd3; wr_data = 5'h1A;
    run_to(68); wr_en = 1'b0;
    chk("live_seg", seg_a, 8'h08);

    run_to(127); chk("dis_pre", en_a, 8'hDF);
    disp_on = 1'b0;
    run_to(128); chk("dis_off", en_a, 8'hFF); chk("dis_idx", {5'd0, idx_a}, 8'd5);
    run_to(130); disp_on = 1'b1;
    run_to(131); chk("re_k0", en_a, 8'hDF);
    run_to(132); chk("re_k1", en_a, 8'hDF);
    wr_en = 1'b1; wr_addr = 3'd2; wr_data = 5'h01;
    run_to(133); chk("re_k2", en_a, 8'hDF);
    wr_addr = 3'd3; wr_data = 5'h00;
    run_to(134); chk("re_k3", en_a, 8'hDF);
    wr_en = 1'b0;
    run_to(135); chk("re_gap", en_a, 8'hFF);

    run_to(143); chk("lz_d7", seg_a, LZ ? 8'hFF : 8'hC0); chk("lz_d7_en", en_a, 8'h7F);
    run_to(149); chk("lz_d0", seg_a, 8'hC0);
    run_to(155); chk("lz_d1", seg_a, 8'hC0);
    run_to(161); chk("lz_d2", seg_a, 8'hF9);
    run_to(167); chk("lz_d3", seg_a, LZ ? 8'hFF : 8'hC0); chk("lz_d3_en", en_a, 8'hF7);

    run_to(170);
    #3 rst = 1'b0;
    #1;
    chk("mid_rst_en",  en_a, 8'hFF);
    chk("mid_rst_seg", seg_a, 8'hFF);
    chk("mid_rst_idx", {5'd0, idx_a}, 8'h00);
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    chk("post_rst_en",  en_a, 8'hFE);
    chk("post_rst_seg", seg_a, 8'hC0);
    repeat (13) @(negedge clk);
    chk("post_rst_d2_en",  en_a, 8'hFB);
    chk("post_rst_d2_seg", seg_a, LZ ? 8'hFF : 8'hC0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/seg_scan_ctrl.md
SEG_SCAN_CTRL -- requirements
Module: seg_scan_ctrl

Interface
REQ-001 Parameter SCAN_DIV, default 50000, sets clk cycles each digit is driven (range 1..65535).
REQ-002 Parameter GAP_CYC, default 8, sets blank clk cycles between digits (range 0..255).
REQ-003 clk  input  1  system clock; all state changes on its rising edge.
REQ-004 rst  input  1  asynchronous, active-low reset.
REQ-005 disp_on  input  1  1 = scan display, 0 = all digits dark.
REQ-006 wr_en  input  1  digit register write strobe, one write per asserted cycle.
REQ-007 wr_addr  input  3  digit index to write; 0 = least significant, 7 = most significant.
REQ-008 wr_data  input  5  bit4 = decimal point on, bits3:0 = hex value.
REQ-009 seg  output  8  active-low segments {dp,g,f,e,d,c,b,a}.
REQ-010 en  output  8  active-low digit enables; at most one bit low.
REQ-011 digit_idx  output  3  index of the digit currently selected by the scanner.

Function
REQ-012 Block SHALL hold eight 5-bit digit registers; a write with wr_en=1 SHALL update reg[wr_addr] at that clock edge.
REQ-013 FSM SHALL have states OFF, DRIVE, GAP, with a 16-bit cycle counter cnt and 3-bit index idx (idx drives digit_idx).
REQ-014 OFF: en=8'hFF, seg=8'hFF; when disp_on=1, go to DRIVE with cnt=0 and idx unchanged.
REQ-015 DRIVE: en=~(8'h01<<idx), seg=decode(reg[idx]); cnt increments; at cnt==SCAN_DIV-1, go to GAP with cnt=0.
REQ-016 GAP: en=8'hFF, seg=8'hFF; at cnt==GAP_CYC-1, go to DRIVE with cnt=0 and idx=idx+1, wrapping 7->0.
REQ-017 If GAP_CYC==0, DRIVE SHALL go directly to DRIVE at end of count with idx+1; GAP SHALL never be entered.
REQ-018 disp_on=0 in DRIVE or GAP SHALL force OFF at the next edge, with idx retained and cnt cleared; re-enable SHALL restart the retained digit with a full SCAN_DIV period.
REQ-019 en and seg SHALL be combinational decodes of state, idx and reg[idx], adding no latency; a write to the driven digit SHALL appear on seg immediately after the write edge.
REQ-020 decode bits6:0 for values 0-F SHALL be: C0,F9,A4,B0,99,92,82,F8,80,90,88,83,C6,A1,86,8E (low 7 bits); seg[7]=~dp.
REQ-021 If a write coincides with a state transition, both SHALL take effect at the same edge.

Reset
REQ-022 When rst=0, the block SHALL asynchronously force state=OFF, idx=0, cnt=0 and all digit registers=0, giving en=8'hFF and seg=8'hFF.
REQ-023 After rst deasserts, the first DRIVE SHALL be digit 0 with a full SCAN_DIV period.
REQ-024 rst asserted mid-scan SHALL discard the current period and the register contents.

Configuration
REQ-025 Macro SEG_LZ_BLANK_EN defined: in DRIVE, digit i (i>=1) SHALL output seg=8'hFF (en still asserted) when it and every digit above it hold value 0 with dp=0.
REQ-026 Digit 0 SHALL never be blanked.
REQ-027 Macro SEG_LZ_BLANK_EN undefined: all digits SHALL always be decoded per REQ-020.

Verification (SCAN_DIV=4, GAP_CYC=2 unless noted)
REQ-028 Reset: hold rst=0 -> en=FF, seg=FF, digit_idx=0; after release with disp_on=1 -> en=FE, seg=C0.
REQ-029 Scan: disp_on=1 -> en=FE for 4 cycles, FF for 2, FD for 4, continuing through 7F; en=FE returns at cycle 48.
REQ-030 Live write: while digit 3 is driven, write addr=3, data=5'h1A -> seg=08 after that edge.
REQ-031 Disable: drop disp_on at the 2nd DRIVE cycle of idx 5 -> en=FF at the next edge; re-raise -> en=DF for 4 full cycles.
REQ-032 Blanking: reg2=1, others 0 -> with macro, digits 3-7 give seg=FF, digits 0-1 give C0, digit 2 gives F9; without macro, digits 0,1,3-7 give C0.
REQ-033 GAP_CYC=0: en steps FE->FD->FB every 4 cycles with no FF cycles.
